fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Pipeline front-end controller that sequences the instruction-fetch slice. It arbitrates the PC-source selects (call, branch, return) so that at most one is ever asserted. It generates PC stall and IF/ID, ID/EX flush/bubble controls for load-use hazards, returns and halt drain. It also keeps a saturating stall-cycle performance counter. It sits beside the IF slice and drives its stall/Call/Branch/Ret inputs combinationally in the same cycle.

Parameters:
LU_CYCLES, 1, load-use stall length in cycles (legal 1..15)
DRAIN_CYCLES, 3, cycles spent draining the pipeline after halt decode before HALTED (legal 1..15)
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
load_use  input  1  ID instr depends on load currently in EX
call_ex  input  1  call resolved in EX
branch_ex  input  1  taken branch resolved in EX
ret_id  input  1  return decoded in ID
ret_mem  input  1  return target available from MEM
halt_id  input  1  halt decoded in ID
stall  output  1  hold PC (to IF slice stall)
Call  output  1  select PCcall
Branch  output  1  select PCbranch
Ret  output  1  select PCret
stall_ifid  output  1  hold IF/ID register
bubble_idex  output  1  insert NOP into ID/EX
flush_ifid  output  1  squash IF/ID contents
flush_idex  output  1  squash ID/EX contents
halted  output  1  core halted
stall_count  output  CNT_W  cycles with stall=1 outside HALTED

Behaviour:
- States: RUN, LU_STALL, RET_WAIT, DRAIN, HALTED. 4-bit down-counter cnt. All outputs are Mealy (combinational from state and inputs). State, cnt and stall_count are registered.
- Reset (async, rst=1): state=RUN, cnt=0, stall_count=0. While rst=1, all outputs are forced to 0.
- Redirect rule, in any state except HALTED: call_ex or branch_ex takes priority over every other input.
  - If call_ex=1: Call=1 only.
  - Else if branch_ex=1: Branch=1 only.
  - Either case: flush_ifid=1, flush_idex=1, stall=0, next state=RUN, cnt=0.
  - Same-cycle ret_id, halt_id and load_use are ignored as wrong-path.
  - Only one of Call, Branch, Ret is ever asserted.
- RUN, no redirect. The first matching input applies:
  - ret_mem=1: Ret=1, flush_ifid=1, flush_idex=1. Stay in RUN.
  - ret_id=1: stall=1, flush_ifid=1. Go to RET_WAIT.
  - halt_id=1: stall=1, flush_ifid=1, cnt=DRAIN_CYCLES-1. Go to DRAIN, or go straight to HALTED if DRAIN_CYCLES=1.
  - load_use=1: stall=1, stall_ifid=1, bubble_idex=1. If LU_CYCLES=1, stay in RUN. Otherwise cnt=LU_CYCLES-1 and go to LU_STALL.
- LU_STALL, no redirect: stall=1, stall_ifid=1, bubble_idex=1. Decrement cnt. When cnt==1, go to RUN. New load_use is ignored until back in RUN.
- RET_WAIT, no redirect: stall=1, flush_ifid=1 every cycle. On ret_mem=1: Ret=1, stall=0, flush_ifid=1, flush_idex=1, go to RUN. No timeout.
- DRAIN, no redirect: stall=1, flush_ifid=1. Decrement cnt. When cnt==1, go to HALTED. A redirect cancels the halt and returns to RUN.
- HALTED: stall=1, halted=1, all other outputs 0. All inputs are ignored. Exit only via rst.
- stall_count increments by 1 on each clock where stall=1 and state!=HALTED. It saturates at all-ones with no wrap.

Test Plan:
- Reset mid-RET_WAIT: ret_id, 2 idle cycles, assert rst -> all outputs 0 immediately, state=RUN, stall_count=0 after release.
- Load-use, LU_CYCLES=2: load_use pulse 1 cycle -> stall=stall_ifid=bubble_idex=1 for exactly 2 cycles, then 0; stall_count=2.
- Return: ret_id, 3 idle cycles, ret_mem -> stall=1 for 4 cycles. On the ret_mem cycle: Ret=1, stall=0, flush_ifid=flush_idex=1. Next cycle all outputs 0.
- Simultaneous call_ex, branch_ex, load_use, ret_id -> Call=1, Branch=0, Ret=0, flush_ifid=flush_idex=1, stall=0. Next cycle state RUN.
- Halt, DRAIN_CYCLES=3: halt_id -> stall=1 for 3 cycles, then halted=1 permanently. stall_count holds at 3 afterwards. Repeat with branch_ex in the 2nd drain cycle -> Branch=1, back to RUN, halted never set.
- Counter saturation, CNT_W=4: hold ret_id then stay in RUN_WAIT for 20 cycles -> stall_count reaches 15 and stays 15.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Hazard/redirect inputs and PC-select/stall/flush outputs between the
// pipeline and the fetch controller.
interface fetch_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             load_use;
   logic             call_ex;
   logic             branch_ex;
   logic             ret_id;
   logic             ret_mem;
   logic             halt_id;
   logic             stall;
   logic             Call;
   logic             Branch;
   logic             Ret;
   logic             stall_ifid;
   logic             bubble_idex;
   logic             flush_ifid;
   logic             flush_idex;
   logic             halted;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output load_use, call_ex, branch_ex, ret_id, ret_mem, halt_id,
      input  stall, Call, Branch, Ret, stall_ifid, bubble_idex,
             flush_ifid, flush_idex, halted, stall_count
   );

   modport slave (
      input  load_use, call_ex, branch_ex, ret_id, ret_mem, halt_id,
      output stall, Call, Branch, Ret, stall_ifid, bubble_idex,
             flush_ifid, flush_idex, halted, stall_count
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Front-end controller: one-hot PC-source select, load-use/return/halt stall
// and flush sequencing, plus a saturating stall-cycle counter.
module fetch_ctrl #(
   parameter int LU_CYCLES    = 1,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input logic         clk,
   input logic         rst,
   fetch_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      RUN,
      LU_STALL,
      RET_WAIT,
      DRAIN,
      HALTED
   } state_t;

   state_t           state_reg, state_next;
   logic [3:0]       cnt_reg, cnt_next;
   logic [CNT_W-1:0] stall_count_reg;

   logic stall_c, call_c, branch_c, ret_c;
   logic stall_ifid_c, bubble_idex_c, flush_ifid_c, flush_idex_c, halted_c;

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      stall_c       = 1'b0;
      call_c        = 1'b0;
      branch_c      = 1'b0;
      ret_c         = 1'b0;
      stall_ifid_c  = 1'b0;
      bubble_idex_c = 1'b0;
      flush_ifid_c  = 1'b0;
      flush_idex_c  = 1'b0;
      halted_c      = 1'b0;

      // A resolved redirect in EX squashes everything younger, so any
      // same-cycle ID/hazard request is wrong-path and dropped.
      if (state_reg != HALTED && (bus.call_ex || bus.branch_ex)) begin
         call_c       = bus.call_ex;
         branch_c     = ~bus.call_ex & bus.branch_ex;
         flush_ifid_c = 1'b1;
         flush_idex_c = 1'b1;
         state_next   = RUN;
         cnt_next     = 4'd0;
      end else begin
         case (state_reg)
            RUN: begin
               if (bus.ret_mem) begin
                  ret_c        = 1'b1;
                  flush_ifid_c = 1'b1;
                  flush_idex_c = 1'b1;
               end else if (bus.ret_id) begin
                  stall_c      = 1'b1;
                  flush_ifid_c = 1'b1;
                  state_next   = RET_WAIT;
               end else if (bus.halt_id) begin
                  stall_c      = 1'b1;
                  flush_ifid_c = 1'b1;
                  cnt_next     = 4'(DRAIN_CYCLES - 1);
                  state_next   = (DRAIN_CYCLES == 1) ? HALTED : DRAIN;
               end else if (bus.load_use) begin
                  stall_c       = 1'b1;
                  stall_ifid_c  = 1'b1;
                  bubble_idex_c = 1'b1;
                  if (LU_CYCLES > 1) begin
                     cnt_next   = 4'(LU_CYCLES - 1);
                     state_next = LU_STALL;
                  end
               end
            end
            LU_STALL: begin
               stall_c       = 1'b1;
               stall_ifid_c  = 1'b1;
               bubble_idex_c = 1'b1;
               cnt_next      = cnt_reg - 4'd1;
               if (cnt_reg == 4'd1) state_next = RUN;
            end
            RET_WAIT: begin
               flush_ifid_c = 1'b1;
               if (bus.ret_mem) begin
                  ret_c        = 1'b1;
                  flush_idex_c = 1'b1;
                  state_next   = RUN;
               end else begin
                  stall_c = 1'b1;
               end
            end
            DRAIN: begin
               stall_c      = 1'b1;
               flush_ifid_c = 1'b1;
               cnt_next     = cnt_reg - 4'd1;
               if (cnt_reg == 4'd1) state_next = HALTED;
            end
            HALTED: begin
               stall_c  = 1'b1;
               halted_c = 1'b1;
            end
            default: begin
               state_next = RUN;
               cnt_next   = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= RUN;
         cnt_reg         <= 4'd0;
         stall_count_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (stall_c && state_reg != HALTED && stall_count_reg != {CNT_W{1'b1}})
            stall_count_reg <= stall_count_reg + CNT_W'(1);
      end
   end

   // Outputs are Mealy; reset must silence them without waiting for a clock.
   assign bus.stall       = stall_c       & ~rst;
   assign bus.Call        = call_c        & ~rst;
   assign bus.Branch      = branch_c      & ~rst;
   assign bus.Ret         = ret_c         & ~rst;
   assign bus.stall_ifid  = stall_ifid_c  & ~rst;
   assign bus.bubble_idex = bubble_idex_c & ~rst;
   assign bus.flush_ifid  = flush_ifid_c  & ~rst;
   assign bus.flush_idex  = flush_idex_c  & ~rst;
   assign bus.halted      = halted_c      & ~rst;
   assign bus.stall_count = stall_count_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl (LU_CYCLES=2, DRAIN_CYCLES=3,
// CNT_W=4) plus hand sequences for async reset and counter saturation.
module tb_fetch_ctrl;

   localparam int CNT_W = 4;

   // inputs  {load_use, call_ex, branch_ex, ret_id, ret_mem, halt_id}
   localparam logic [5:0] I_IDLE = 6'b000000;
   localparam logic [5:0] I_LU   = 6'b100000;
   localparam logic [5:0] I_CALL = 6'b010000;
   localparam logic [5:0] I_BR   = 6'b001000;
   localparam logic [5:0] I_RETD = 6'b000100;
   localparam logic [5:0] I_RETM = 6'b000010;
   localparam logic [5:0] I_HALT = 6'b000001;

   // outputs {stall, Call, Branch, Ret, stall_ifid, bubble_idex, flush_ifid, flush_idex, halted}
   localparam logic [8:0] O_IDLE = 9'b000000000;
   localparam logic [8:0] O_LU   = 9'b100011000;
   localparam logic [8:0] O_SFL  = 9'b100000100;
   localparam logic [8:0] O_RETM = 9'b000100110;
   localparam logic [8:0] O_CALL = 9'b010000110;
   localparam logic [8:0] O_BR   = 9'b001000110;
   localparam logic [8:0] O_HALT = 9'b100000001;

   typedef struct {
      string      name;
      logic [5:0] in;
      logic [8:0] out;
      logic [3:0] cnt;
   } vec_t;

   logic clk;
   logic rst;
   int   total;
   int   passed;

   fetch_ctrl_if #(.CNT_W(CNT_W)) bus ();

   fetch_ctrl #(
      .LU_CYCLES   (2),
      .DRAIN_CYCLES(3),
      .CNT_W       (CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [8:0] outs();
      return {bus.stall, bus.Call, bus.Branch, bus.Ret, bus.stall_ifid,
              bus.bubble_idex, bus.flush_ifid, bus.flush_idex, bus.halted};
   endfunction

   task automatic drive(input logic [5:0] v);
      {bus.load_use, bus.call_ex, bus.branch_ex, bus.ret_id, bus.ret_mem, bus.halt_id} = v;
   endtask

   task automatic check(input string name, input logic [8:0] exp_out, input logic [3:0] exp_cnt);
      logic [8:0] got;
      got = outs();
      total++;
      if (got === exp_out) passed++;
      else $display("FAIL %s outputs: got %b expected %b", name, got, exp_out);
      total++;
      if (bus.stall_count === exp_cnt) passed++;
      else $display("FAIL %s stall_count: got %0d expected %0d", name, bus.stall_count, exp_cnt);
      $display("txn %-12s in=%b out=%b cnt=%0d", name, {bus.load_use, bus.call_ex, bus.branch_ex,
               bus.ret_id, bus.ret_mem, bus.halt_id}, got, bus.stall_count);
   endtask

   task automatic step(input string name, input logic [5:0] v, input logic [8:0] exp_out,
                       input logic [3:0] exp_cnt);
      @(negedge clk);
      drive(v);
      #1;
      check(name, exp_out, exp_cnt);
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(I_IDLE);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   vec_t vecs[27];

   initial begin
      total  = 0;
      passed = 0;
      rst    = 1'b1;
      drive(I_CALL | I_HALT);

      vecs[0]  = '{"idle",       I_IDLE,                        O_IDLE, 4'd0};
      vecs[1]  = '{"lu",         I_LU,                          O_LU,   4'd0};
      vecs[2]  = '{"lu_hold",    I_LU,                          O_LU,   4'd1};
      vecs[3]  = '{"lu_done",    I_IDLE,                        O_IDLE, 4'd2};
      vecs[4]  = '{"ret_id",     I_RETD,                        O_SFL,  4'd2};
      vecs[5]  = '{"ret_w1",     I_IDLE,                        O_SFL,  4'd3};
      vecs[6]  = '{"ret_w2",     I_IDLE,                        O_SFL,  4'd4};
      vecs[7]  = '{"ret_w3",     I_IDLE,                        O_SFL,  4'd5};
      vecs[8]  = '{"ret_mem",    I_RETM,                        O_RETM, 4'd6};
      vecs[9]  = '{"ret_after",  I_IDLE,                        O_IDLE, 4'd6};
      vecs[10] = '{"multi",      I_LU | I_CALL | I_BR | I_RETD, O_CALL, 4'd6};
      vecs[11] = '{"multi_aft",  I_IDLE,                        O_IDLE, 4'd6};
      vecs[12] = '{"br_halt",    I_BR | I_HALT,                 O_BR,   4'd6};
      vecs[13] = '{"br_aft",     I_IDLE,                        O_IDLE, 4'd6};
      vecs[14] = '{"lu2",        I_LU,                          O_LU,   4'd6};
      vecs[15] = '{"lu_call",    I_CALL,                        O_CALL, 4'd7};
      vecs[16] = '{"lu_call_a",  I_IDLE,                        O_IDLE, 4'd7};
      vecs[17] = '{"halt1",      I_HALT,                        O_SFL,  4'd7};
      vecs[18] = '{"drain_br",   I_BR,                          O_BR,   4'd8};
      vecs[19] = '{"retm_prio",  I_RETD | I_RETM,               O_RETM, 4'd8};
      vecs[20] = '{"idle2",      I_IDLE,                        O_IDLE, 4'd8};
      vecs[21] = '{"halt2",      I_HALT,                        O_SFL,  4'd8};
      vecs[22] = '{"drain1",     I_IDLE,                        O_SFL,  4'd9};
      vecs[23] = '{"drain2",     I_IDLE,                        O_SFL,  4'd10};
      vecs[24] = '{"halted",     I_IDLE,                        O_HALT, 4'd11};
      vecs[25] = '{"halt_call",  I_CALL | I_RETM,               O_HALT, 4'd11};
      vecs[26] = '{"halt_lu",    I_LU | I_HALT,                 O_HALT, 4'd11};

      // Outputs must be silent while reset is held, whatever the inputs say.
      #1;
      check("rst_hold", O_IDLE, 4'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 27; i++)
         step(vecs[i].name, vecs[i].in, vecs[i].out, vecs[i].cnt);

      // Async reset in the middle of RET_WAIT.
      do_reset();
      step("rw_ret_id", I_RETD, O_SFL, 4'd0);
      step("rw_idle1", I_IDLE, O_SFL, 4'd1);
      step("rw_idle2", I_IDLE, O_SFL, 4'd2);
      rst = 1'b1;
      #1;
      check("rw_rst", O_IDLE, 4'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rw_release", O_IDLE, 4'd0);
      step("rw_run", I_IDLE, O_IDLE, 4'd0);

      // Stall counter saturation while parked in RET_WAIT.
      do_reset();
      step("sat_ret_id", I_RETD, O_SFL, 4'd0);
      for (int i = 1; i <= 20; i++)
         step($sformatf("sat_w%0d", i), I_IDLE, O_SFL, (i < 15) ? 4'(i) : 4'd15);
      step("sat_hold", I_IDLE, O_SFL, 4'd15);
      step("sat_retm", I_RETM, O_RETM, 4'd15);
      step("sat_after", I_IDLE, O_IDLE, 4'd15);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
